// File: rtl/wb2axi4lite_bridge.sv
// Wishbone B3 classic slave to AXI4-Lite master bridge.
// Each strobe becomes exactly one single-beat AXI write or read; every output is registered.
module wb2axi4lite_bridge #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] AXPROT     = 3'b000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  // state | meaning
  // IDLE  | wait for cyc&stb, capture the request
  // WR    | AW and/or W still outstanding
  // WB    | await write response
  // RD    | AR outstanding
  // RR    | await read data
  // DONE  | one-cycle ack/err (suppressed if the initiator aborted)
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WB, S_RD, S_RR, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_abort;
  logic   w_abort_nxt;
  logic   w_aborting;

  logic [ADDR_WIDTH-1:0]   w_awaddr_nxt;
  logic                    w_awvalid_nxt;
  logic [DATA_WIDTH-1:0]   w_wdata_nxt;
  logic [DATA_WIDTH/8-1:0] w_wstrb_nxt;
  logic                    w_wvalid_nxt;
  logic                    w_bready_nxt;
  logic [ADDR_WIDTH-1:0]   w_araddr_nxt;
  logic                    w_arvalid_nxt;
  logic                    w_rready_nxt;
  logic [DATA_WIDTH-1:0]   w_dat_nxt;
  logic                    w_ack_nxt;
  logic                    w_err_nxt;

  assign m_awprot   = AXPROT;
  assign m_arprot   = AXPROT;
  assign w_aborting = r_abort | ~wb_cyc_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_abort_nxt   = r_abort;
    w_awaddr_nxt  = m_awaddr;
    w_awvalid_nxt = m_awvalid;
    w_wdata_nxt   = m_wdata;
    w_wstrb_nxt   = m_wstrb;
    w_wvalid_nxt  = m_wvalid;
    w_bready_nxt  = m_bready;
    w_araddr_nxt  = m_araddr;
    w_arvalid_nxt = m_arvalid;
    w_rready_nxt  = m_rready;
    w_dat_nxt     = wb_dat_o;
    w_ack_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_abort_nxt = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          if (wb_we_i) begin
            w_awaddr_nxt  = wb_adr_i;
            w_wdata_nxt   = wb_dat_i;
            w_wstrb_nxt   = wb_sel_i;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_WR;
          end else begin
            w_araddr_nxt  = wb_adr_i;
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_RD;
          end
        end
      end
      S_WR: begin
        w_abort_nxt = w_aborting;
        if (m_awvalid && m_awready) w_awvalid_nxt = 1'b0;
        if (m_wvalid && m_wready)   w_wvalid_nxt  = 1'b0;
        // A dropped valid means that channel already handshook on an earlier edge.
        if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WB;
        end
      end
      S_WB: begin
        w_abort_nxt = w_aborting;
        if (m_bvalid && m_bready) begin
          w_bready_nxt = 1'b0;
          w_ack_nxt    = ~w_aborting & (m_bresp == 2'b00);
          w_err_nxt    = ~w_aborting & (m_bresp != 2'b00);
          w_state_nxt  = S_DONE;
        end
      end
      S_RD: begin
        w_abort_nxt = w_aborting;
        if (m_arvalid && m_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RR;
        end
      end
      S_RR: begin
        w_abort_nxt = w_aborting;
        if (m_rvalid && m_rready) begin
          w_dat_nxt    = m_rdata;
          w_rready_nxt = 1'b0;
          w_ack_nxt    = ~w_aborting & (m_rresp == 2'b00);
          w_err_nxt    = ~w_aborting & (m_rresp != 2'b00);
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      wb_dat_o  <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
    end else begin
      m_awaddr  <= w_awaddr_nxt;
      m_awvalid <= w_awvalid_nxt;
      m_wdata   <= w_wdata_nxt;
      m_wstrb   <= w_wstrb_nxt;
      m_wvalid  <= w_wvalid_nxt;
      m_bready  <= w_bready_nxt;
      m_araddr  <= w_araddr_nxt;
      m_arvalid <= w_arvalid_nxt;
      m_rready  <= w_rready_nxt;
      wb_dat_o  <= w_dat_nxt;
      wb_ack_o  <= w_ack_nxt;
      wb_err_o  <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_wb2axi4lite_bridge.sv
// Bench for wb2axi4lite_bridge: directed Wishbone transfers against a delay-configurable
// AXI4-Lite slave; expectations are queued at issue time and checked by a negedge monitor.
module tb_wb2axi4lite_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  wb2axi4lite_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int hold; } a_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; int hold; } w_exp_t;
  typedef struct { bit err; bit rd; logic [31:0] dat; int lat; } wb_exp_t;

  a_exp_t  aw_q[$];
  a_exp_t  ar_q[$];
  w_exp_t  w_q[$];
  wb_exp_t wb_q[$];

  int checks = 0, errors = 0;
  int cyc_cnt = 0, t_start = 0;
  int n_b = 0, n_r = 0, n_wb = 0, exp_b = 0, exp_r = 0, exp_wb = 0;

  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_awvalid"}, {31'b0, m_awvalid}, 0);
    chk({tag, "_wvalid"},  {31'b0, m_wvalid},  0);
    chk({tag, "_bready"},  {31'b0, m_bready},  0);
    chk({tag, "_arvalid"}, {31'b0, m_arvalid}, 0);
    chk({tag, "_rready"},  {31'b0, m_rready},  0);
    chk({tag, "_ack"},     {31'b0, wb_ack_o},  0);
    chk({tag, "_err"},     {31'b0, wb_err_o},  0);
    chk({tag, "_dat"},     wb_dat_o, 0);
    chk({tag, "_awaddr"},  m_awaddr, 0);
    chk({tag, "_araddr"},  m_araddr, 0);
    chk({tag, "_wdata"},   m_wdata,  0);
    chk({tag, "_wstrb"},   {28'b0, m_wstrb}, 0);
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc_cnt++;
  end

  // AXI4-Lite slave: each ready/valid rises a programmable number of cycles after its trigger.
  int aw_c = 0, w_c = 0, ar_c = 0, b_c = 0, r_c = 0;
  initial begin
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_i) begin
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
      end else begin
        if (m_awready) m_awready = 0;
        else if (m_awvalid) begin
          if (aw_c >= cfg_aw_dly) begin m_awready = 1; aw_c = 0; end else aw_c++;
        end else aw_c = 0;
        if (m_wready) m_wready = 0;
        else if (m_wvalid) begin
          if (w_c >= cfg_w_dly) begin m_wready = 1; w_c = 0; end else w_c++;
        end else w_c = 0;
        if (m_arready) m_arready = 0;
        else if (m_arvalid) begin
          if (ar_c >= cfg_ar_dly) begin m_arready = 1; ar_c = 0; end else ar_c++;
        end else ar_c = 0;
        if (m_bvalid) begin
          if (!m_bready) m_bvalid = 0;
        end else if (m_bready) begin
          if (b_c >= cfg_b_dly) begin m_bvalid = 1; m_bresp = cfg_bresp; b_c = 0; end else b_c++;
        end else b_c = 0;
        if (m_rvalid) begin
          if (!m_rready) m_rvalid = 0;
        end else if (m_rready) begin
          if (r_c >= cfg_r_dly) begin
            m_rvalid = 1; m_rresp = cfg_rresp; m_rdata = cfg_rdata; r_c = 0;
          end else r_c++;
        end else r_c = 0;
      end
    end
  end

  // Monitor / scoreboard
  int          aw_h = 0, w_h = 0, ar_h = 0;
  logic [31:0] exp_dat = 0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
  a_exp_t      mon_a;
  w_exp_t      mon_w;
  wb_exp_t     mon_e;

  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      exp_dat = 0;
      aw_h = 0; w_h = 0; ar_h = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    end else begin
      if (p_awv && !p_awr) begin
        chk("aw_valid_held", {31'b0, m_awvalid}, 1);
        chk("aw_addr_stable", m_awaddr, p_awaddr);
      end
      if (p_wv && !p_wr) begin
        chk("w_valid_held", {31'b0, m_wvalid}, 1);
        chk("w_data_stable", m_wdata, p_wdata);
      end
      if (p_arv && !p_arr) begin
        chk("ar_valid_held", {31'b0, m_arvalid}, 1);
        chk("ar_addr_stable", m_araddr, p_araddr);
      end

      if (m_awvalid) aw_h++;
      if (m_awvalid && m_awready) begin
        if (aw_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected got=1 exp=0 addr=%h", m_awaddr);
        end else begin
          mon_a = aw_q.pop_front();
          chk("aw_addr", m_awaddr, mon_a.addr);
          chk("aw_hold", aw_h, mon_a.hold);
        end
        aw_h = 0;
      end
      if (m_wvalid) w_h++;
      if (m_wvalid && m_wready) begin
        if (w_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected got=1 exp=0 data=%h", m_wdata);
        end else begin
          mon_w = w_q.pop_front();
          chk("w_data", m_wdata, mon_w.data);
          chk("w_strb", {28'b0, m_wstrb}, {28'b0, mon_w.strb});
          chk("w_hold", w_h, mon_w.hold);
        end
        w_h = 0;
      end
      if (m_arvalid) ar_h++;
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_unexpected got=1 exp=0 addr=%h", m_araddr);
        end else begin
          mon_a = ar_q.pop_front();
          chk("ar_addr", m_araddr, mon_a.addr);
          chk("ar_hold", ar_h, mon_a.hold);
        end
        ar_h = 0;
      end
      if (m_bvalid && m_bready) n_b++;
      if (m_rvalid && m_rready) n_r++;

      if (wb_ack_o && wb_err_o) begin
        checks++; errors++;
        $display("FAIL ack_err_both got=11 exp=not_both");
      end
      if (wb_ack_o || wb_err_o) begin
        n_wb++;
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected_resp got ack=%b err=%b exp=none", wb_ack_o, wb_err_o);
        end else begin
          mon_e = wb_q.pop_front();
          chk("wb_err", {31'b0, wb_err_o}, {31'b0, mon_e.err});
          chk("wb_ack", {31'b0, wb_ack_o}, {31'b0, !mon_e.err});
          if (mon_e.rd) exp_dat = mon_e.dat;
          if (mon_e.lat >= 0) chk("wb_latency", cyc_cnt - t_start, mon_e.lat);
        end
      end
      chk("wb_dat_o", wb_dat_o, exp_dat);

      p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
      p_wv = m_wvalid;   p_wr = m_wready;   p_wdata = m_wdata;
      p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the response cycle.
  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit exp_err, input int lat);
    a_exp_t  a;
    w_exp_t  w;
    wb_exp_t e;
    int      n;
    if (we) begin
      a.addr = adr; a.hold = cfg_aw_dly + 1; aw_q.push_back(a);
      w.data = dat; w.strb = sel; w.hold = cfg_w_dly + 1; w_q.push_back(w);
      exp_b++;
    end else begin
      a.addr = adr; a.hold = cfg_ar_dly + 1; ar_q.push_back(a);
      exp_r++;
    end
    e.err = exp_err; e.rd = !we; e.dat = cfg_rdata; e.lat = lat;
    wb_q.push_back(e);
    exp_wb++;
    t_start = cyc_cnt;
    wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1; wb_stb_i = 1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(wb_ack_o || wb_err_o) && n < 100);
    if (!(wb_ack_o || wb_err_o)) begin
      checks++; errors++;
      $display("FAIL wb_timeout got=no_resp exp=resp adr=%h", adr);
    end
    @(posedge clk_i);
    #1;
    wb_cyc_i = 0; wb_stb_i = 0;
  endtask

  task automatic wait_sig(input string name, input bit want_bready, input bit lvl);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (((want_bready ? m_bready : m_rready) !== lvl) && n < 100);
    if ((want_bready ? m_bready : m_rready) !== lvl) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=%b exp=%b", name, !lvl, lvl);
    end
  endtask

  a_exp_t s_a;
  w_exp_t s_w;

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1;
    wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0; wb_we_i = 0; wb_cyc_i = 0; wb_stb_i = 0;
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset");
    chk("awprot", {29'b0, m_awprot}, 0);
    chk("arprot", {29'b0, m_arprot}, 0);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(posedge clk_i); #1;

    // 1: minimum-latency write
    wb_xfer(1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0, 3);

    // 2: read with arready held off; arvalid high for 4 cycles
    cfg_ar_dly = 3; cfg_rdata = 32'h1234_5678;
    wb_xfer(0, 32'h0000_0104, 32'h0, 4'h0, 0, 6);
    cfg_ar_dly = 0;
    repeat (3) @(posedge clk_i);
    #1;

    // 3: W completes three cycles before AW
    cfg_aw_dly = 3;
    wb_xfer(1, 32'h0000_0200, 32'hA5A5_1234, 4'h3, 0, 6);
    cfg_aw_dly = 0;

    // 4: SLVERR read, DECERR write, zero-strobe write
    cfg_rresp = 2'b10; cfg_rdata = 32'hCAFE_F00D;
    wb_xfer(0, 32'h0000_0300, 32'h0, 4'h0, 1, 3);
    cfg_rresp = 2'b00;
    cfg_bresp = 2'b11;
    wb_xfer(1, 32'h0000_0304, 32'h0BAD_0BAD, 4'hC, 1, 3);
    cfg_bresp = 2'b00;
    wb_xfer(1, 32'h0000_0308, 32'h1111_2222, 4'h0, 0, 3);

    // 5: initiator drops cyc while the write response is pending
    cfg_b_dly = 5;
    s_a.addr = 32'h0000_0400; s_a.hold = 1; aw_q.push_back(s_a);
    s_w.data = 32'h55AA_55AA; s_w.strb = 4'hF; s_w.hold = 1; w_q.push_back(s_w);
    exp_b++;
    wb_we_i = 1; wb_adr_i = 32'h0000_0400; wb_dat_i = 32'h55AA_55AA; wb_sel_i = 4'hF;
    wb_cyc_i = 1; wb_stb_i = 1;
    wait_sig("abort_bready_high", 1, 1);
    @(posedge clk_i); #1;
    wb_cyc_i = 0; wb_stb_i = 0;
    wait_sig("abort_bready_low", 1, 0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("abort_b_done", n_b, exp_b);
    cfg_b_dly = 0;
    cfg_rdata = 32'h0F0F_0F0F;
    wb_xfer(0, 32'h0000_0404, 32'h0, 4'h0, 0, 3);

    // 6: async reset while waiting for read data
    cfg_r_dly = 6;
    s_a.addr = 32'h0000_0500; s_a.hold = 1; ar_q.push_back(s_a);
    wb_we_i = 0; wb_adr_i = 32'h0000_0500; wb_cyc_i = 1; wb_stb_i = 1;
    wait_sig("rr_rready_high", 0, 1);
    @(posedge clk_i); #3;
    rst_i = 1;
    #1;
    check_outputs_zero("mid_rst");
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge clk_i); #2;
    rst_i = 0;
    @(posedge clk_i); #1;
    cfg_r_dly = 0;
    cfg_rdata = 32'h7777_8888;
    wb_xfer(1, 32'h0000_0600, 32'h6060_6060, 4'hF, 0, 3);
    wb_xfer(0, 32'h0000_0604, 32'h0, 4'h0, 0, 3);

    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty",  w_q.size(),  0);
    chk("ar_q_empty", ar_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    chk("b_count",  n_b,  exp_b);
    chk("r_count",  n_r,  exp_r);
    chk("wb_count", n_wb, exp_wb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
